// File: rtl/rank_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : rank_sort_engine
// Brief    : Sequential odd-even transposition sorter with median and
//            run-time selectable order-statistic output.
// Revision : 1.0 - initial release
// ============================================================================
module rank_sort_engine #(
    parameter int NUM_VALS = 9,
    parameter int SIZE     = 8,
    parameter int RANK_W   = $clog2(NUM_VALS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_VALS*SIZE-1:0] in,
    input  logic [RANK_W-1:0]        rank,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_VALS*SIZE-1:0] out,
    output logic [SIZE-1:0]          sel,
    output logic [SIZE-1:0]          median,
    output logic                     busy
);

    localparam int c_phase_w = $clog2(NUM_VALS + 1);
    localparam int c_med_idx = (NUM_VALS % 2 == 1) ? NUM_VALS / 2 : NUM_VALS / 2 - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SIZE-1:0]        a_q    [NUM_VALS];
    logic [SIZE-1:0]        a_d    [NUM_VALS];
    logic [SIZE-1:0]        in_arr [NUM_VALS];
    logic [RANK_W-1:0]      rank_q;
    logic [c_phase_w-1:0]   phase_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   clamp;
    logic [RANK_W-1:0]      sel_idx;

    genvar g;
    generate
        for (g = 0; g < NUM_VALS; g++) begin : g_pack
            assign in_arr[g] = in[(NUM_VALS-1-g)*SIZE +: SIZE];
            assign out[(NUM_VALS-1-g)*SIZE +: SIZE] = a_q[g];
        end
    endgenerate

    // Pairs start at even indices on even phases, odd indices on odd phases;
    // pairs never overlap, so each element is written at most once.
    always_comb begin
        a_d = a_q;
        for (int i = 0; i < NUM_VALS - 1; i++) begin
            if ((i[0] == phase_q[0]) && (a_q[i] > a_q[i+1])) begin
                a_d[i]   = a_q[i+1];
                a_d[i+1] = a_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '{default: '0};
            rank_q      <= '0;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_arr;
                        rank_q  <= rank;
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SORT;
                    end
                end
                S_SORT: begin
                    a_q     <= a_d;
                    phase_q <= phase_q + 1'b1;
                    if (phase_q == c_phase_w'(NUM_VALS - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Out-of-range ranks saturate to the maximum element.
    assign clamp   = ({1'b0, rank_q} >= (RANK_W+1)'(NUM_VALS));
    assign sel_idx = clamp ? RANK_W'(NUM_VALS - 1) : rank_q;

    assign sel       = a_q[sel_idx];
    assign median    = a_q[c_med_idx];
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rank_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rank_sort_engine
// Brief    : Scoreboard bench for rank_sort_engine (N=9/SIZE=8 and N=4/SIZE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rank_sort_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid9 = 1'b0, in_ready9, out_valid9, out_ready9 = 1'b1, busy9;
    logic [71:0] in9 = '0, out9;
    logic [3:0]  rank9 = '0;
    logic [7:0]  sel9, median9;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, busy4;
    logic [15:0] in4 = '0, out4;
    logic [1:0]  rank4 = '0;
    logic [3:0]  sel4, median4;

    typedef struct packed {
        logic [71:0] out;
        logic [7:0]  sel;
        logic [7:0]  med;
        logic [31:0] acc;
    } exp_t;

    exp_t q9[$];
    exp_t q4[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic ov9_prev = 1'b0, ov4_prev = 1'b0;

    rank_sort_engine #(.NUM_VALS(9), .SIZE(8)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid9), .in_ready(in_ready9),
        .in(in9), .rank(rank9), .out_valid(out_valid9), .out_ready(out_ready9),
        .out(out9), .sel(sel9), .median(median9), .busy(busy9)
    );

    rank_sort_engine #(.NUM_VALS(4), .SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in(in4), .rank(rank4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out(out4), .sel(sel4), .median(median4), .busy(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: sort the samples as plain integers, then read off ranks.
    function automatic exp_t model(input logic [71:0] v, input int n, input int sz,
                                   input int rk, input int acc_cyc);
        int   vals[$];
        exp_t e;
        logic [71:0] mask;
        mask = (72'(1) << sz) - 72'(1);
        for (int i = 0; i < n; i++)
            vals.push_back(int'((v >> ((n-1-i)*sz)) & mask));
        vals.sort();
        e.out = '0;
        for (int i = 0; i < n; i++)
            e.out = e.out | (72'(vals[i]) << ((n-1-i)*sz));
        e.sel = 8'(vals[(rk >= n) ? n-1 : rk]);
        e.med = 8'(vals[(n % 2 == 1) ? n/2 : n/2 - 1]);
        e.acc = 32'(acc_cyc);
        return e;
    endfunction

    // Acceptance observers push the expected result at each input handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            q9.delete();
            q4.delete();
        end else begin
            if (in_valid9 && in_ready9) q9.push_back(model(in9, 9, 8, int'(rank9), cyc));
            if (in_valid4 && in_ready4) q4.push_back(model({56'd0, in4}, 4, 4, int'(rank4), cyc));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid9) begin
            if (q9.size() == 0) begin
                chk("spurious_valid9", {71'd0, out_valid9}, 72'd0);
            end else begin
                e = q9[0];
                chk("out9", out9, e.out);
                chk("sel9", {64'd0, sel9}, {64'd0, e.sel});
                chk("median9", {64'd0, median9}, {64'd0, e.med});
                chk("in_ready_in_done9", {71'd0, in_ready9}, 72'd0);
                chk("busy_in_done9", {71'd0, busy9}, 72'd1);
                if (!ov9_prev) chk("latency9", 72'(cyc - int'(e.acc) - 1), 72'd9);
                if (out_ready9) void'(q9.pop_front());
            end
        end
        ov9_prev <= rst_n && out_valid9;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid4) begin
            if (q4.size() == 0) begin
                chk("spurious_valid4", {71'd0, out_valid4}, 72'd0);
            end else begin
                e = q4[0];
                chk("out4", {56'd0, out4}, e.out);
                chk("sel4", {68'd0, sel4}, {64'd0, e.sel});
                chk("median4", {68'd0, median4}, {64'd0, e.med});
                chk("in_ready_in_done4", {71'd0, in_ready4}, 72'd0);
                if (!ov4_prev) chk("latency4", 72'(cyc - int'(e.acc) - 1), 72'd4);
                if (out_ready4) void'(q4.pop_front());
            end
        end
        ov4_prev <= rst_n && out_valid4;
    end

    task automatic send9(input logic [71:0] v, input logic [3:0] rk);
        int t = 0;
        in9 = v; rank9 = rk; in_valid9 = 1'b1;
        while (!in_ready9 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready9) chk("accept_timeout9", {71'd0, in_ready9}, 72'd1);
        @(posedge clk); #1;
        in_valid9 = 1'b0;
    endtask

    task automatic send4(input logic [15:0] v, input logic [1:0] rk);
        int t = 0;
        in4 = v; rank4 = rk; in_valid4 = 1'b1;
        while (!in_ready4 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready4) chk("accept_timeout4", {71'd0, in_ready4}, 72'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    function automatic logic [71:0] pack9(input int v[9]);
        logic [71:0] r = '0;
        for (int i = 0; i < 9; i++) r[(8-i)*8 +: 8] = 8'(v[i]);
        return r;
    endfunction

    task automatic drain();
        int t = 0;
        while ((q9.size() != 0 || q4.size() != 0) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("drain", 72'(q9.size() + q4.size()), 72'd0);
    endtask

    task automatic chk_zero9(input string nm);
        chk({nm, "_out"}, out9, 72'd0);
        chk({nm, "_sel_med"}, {56'd0, sel9, median9}, 72'd0);
        chk({nm, "_valid_busy_ready"}, {69'd0, out_valid9, busy9, in_ready9}, 72'd0);
    endtask

    initial begin
        int v[9];
        logic [71:0] rv;
        logic [71:0] vb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero9("reset");
        chk("reset4", {55'd0, out4, out_valid4, in_ready4}, 72'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {71'd0, in_ready9}, 72'd1);
        @(posedge clk); #1;

        v = '{5, 3, 8, 1, 9, 2, 7, 4, 6};         send9(pack9(v), 4'd0);
        v = '{255, 254, 253, 252, 251, 250, 249, 248, 247}; send9(pack9(v), 4'd15);
        v = '{4, 4, 0, 4, 0, 9, 9, 4, 0};         send9(pack9(v), 4'd3);
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 9; i++)
                rv[(8-i)*8 +: 8] = (k % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            send9(rv, 4'($urandom_range(0, 15)));
        end
        drain();

        // Backpressure: result held while a new vector waits on the input.
        out_ready9 = 1'b0;
        v = '{9, 8, 7, 6, 5, 4, 3, 2, 1};         send9(pack9(v), 4'd8);
        for (int t = 0; t < 100 && !out_valid9; t++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", {71'd0, out_valid9}, 72'd1);
        v = '{10, 200, 30, 30, 0, 77, 150, 255, 1}; vb = pack9(v);
        in9 = vb; rank9 = 4'd6; in_valid9 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {71'd0, in_ready9}, 72'd0);
        end
        out_ready9 = 1'b1;
        send9(vb, 4'd6);
        drain();

        // Reset in the cycle that would perform phase 4.
        v = '{3, 1, 4, 1, 5, 9, 2, 6, 5};         send9(pack9(v), 4'd2);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid_sort", {71'd0, busy9}, 72'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero9("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", {70'd0, in_ready9, out_valid9}, 72'd2);
        @(posedge clk); #1;
        v = '{12, 0, 99, 12, 250, 7, 7, 63, 1};   send9(pack9(v), 4'd4);
        drain();

        send4({4'd3, 4'd0, 4'd15, 4'd7}, 2'd2);
        for (int k = 0; k < 10; k++)
            send4(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
